// File: rtl/data_mem_param.sv
// rtl/data_mem_param.sv - MEM-stage data memory with lane strobes, registered read and post-reset clear sweep
// Accesses are accepted only while ready_o is high; out-of-range accesses flag addr_err_o.
module data_mem_param #(
    parameter int DATA_W     = 8,
    parameter int LANE_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int INIT_CLEAR = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       mem_read_i,
    input  logic                       mem_write_i,
    input  logic [DATA_W/LANE_W-1:0]   wr_strb_i,
    input  logic [ADDR_W-1:0]          address_in_i,
    input  logic [DATA_W-1:0]          data_in_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       rd_valid_o,
    output logic                       ready_o,
    output logic                       addr_err_o
);

    localparam int NLANE = DATA_W / LANE_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    clr_cnt_q;
    logic                ready_q;
    logic                rd_valid_q;
    logic                addr_err_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   old_word;
    logic [DATA_W-1:0]   merged_word;
    logic [DATA_W-1:0]   rd_word_d;
    logic                acc_rd;
    logic                acc_wr;

    assign in_range = ({1'b0, address_in_i} < (ADDR_W+1)'(DEPTH));
    assign idx      = address_in_i[IDX_W-1:0];
    assign old_word = mem_q[idx];
    assign acc_rd   = ready_q & mem_read_i;
    assign acc_wr   = ready_q & mem_write_i;

    // Strobed lanes replace the stored word; also the write-first read value.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < NLANE; i++) begin
            if (wr_strb_i[i]) begin
                merged_word[i*LANE_W +: LANE_W] = data_in_i[i*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        rd_word_d = '0;
        if (in_range) begin
            rd_word_d = acc_wr ? merged_word : old_word;
        end
    end

    // Array has no reset; it is only written by the sweep or an accepted in-range write.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR && !rst_i) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (acc_wr && in_range) begin
            mem_q[idx] <= merged_word;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
            ready_q    <= (INIT_CLEAR == 0);
            clr_cnt_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + IDX_W'(1);
                    if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q   <= ST_IDLE;
                        ready_q   <= 1'b1;
                        clr_cnt_q <= '0;
                    end
                end
                ST_IDLE: begin
                    if (acc_rd) begin
                        rd_data_q  <= rd_word_d;
                        rd_valid_q <= 1'b1;
                    end
                    addr_err_q <= (acc_rd | acc_wr) & ~in_range;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign ready_o    = ready_q;
    assign addr_err_o = addr_err_q;

endmodule

// File: tb/tb_data_mem_param.sv
// tb/tb_data_mem_param.sv - scoreboard bench for data_mem_param (DEPTH 256 and DEPTH 200 instances)
// Stimulus pushes expected responses; a negedge monitor pops and compares on every DUT output.
module tb_data_mem_param;

    typedef struct {
        logic        valid;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        mrd   [2];
    logic        mwr   [2];
    logic [3:0]  strb  [2];
    logic [7:0]  addr  [2];
    logic [31:0] din   [2];
    logic [31:0] rdat  [2];
    logic        rval  [2];
    logic        aerr  [2];
    logic        rdy   [2];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_param #(.DATA_W(32), .LANE_W(8), .ADDR_W(8), .DEPTH(256), .INIT_CLEAR(1)) dut_a (
        .clk_i(clk), .rst_i(rst[0]), .mem_read_i(mrd[0]), .mem_write_i(mwr[0]),
        .wr_strb_i(strb[0]), .address_in_i(addr[0]), .data_in_i(din[0]),
        .rd_data_o(rdat[0]), .rd_valid_o(rval[0]), .ready_o(rdy[0]), .addr_err_o(aerr[0])
    );

    data_mem_param #(.DATA_W(32), .LANE_W(8), .ADDR_W(8), .DEPTH(200), .INIT_CLEAR(1)) dut_b (
        .clk_i(clk), .rst_i(rst[1]), .mem_read_i(mrd[1]), .mem_write_i(mwr[1]),
        .wr_strb_i(strb[1]), .address_in_i(addr[1]), .data_in_i(din[1]),
        .rd_data_o(rdat[1]), .rd_valid_o(rval[1]), .ready_o(rdy[1]), .addr_err_o(aerr[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic mon(input int k);
        exp_t e;
        if (rst[k] || !(rval[k] || aerr[k])) return;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            chk($sformatf("dut%0d unexpected output valid=%0b err=%0b", k, rval[k], aerr[k]), 64'd1, 64'd0);
            return;
        end
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d rd_valid", k), {63'd0, rval[k]}, {63'd0, e.valid});
        chk($sformatf("dut%0d addr_err", k), {63'd0, aerr[k]}, {63'd0, e.err});
        chk($sformatf("dut%0d response cycle", k), 64'(cyc), 64'(e.cyc));
        if (e.valid) chk($sformatf("dut%0d rd_data", k), {32'd0, rdat[k]}, {32'd0, e.data});
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic op(input int k, input logic rd, input logic wr, input logic [3:0] s,
                      input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] ed, input logic ee);
        exp_t e;
        @(posedge clk); #1;
        mrd[k] = rd; mwr[k] = wr; strb[k] = s; addr[k] = a; din[k] = d;
        if (rd || ee) begin
            e.valid = rd; e.err = ee; e.data = ed; e.cyc = cyc + 1;
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic idle(input int k);
        @(posedge clk); #1;
        mrd[k] = 1'b0; mwr[k] = 1'b0; strb[k] = 4'h0;
    endtask

    // Counts edges until ready rises; optionally hammers the DUT with requests meanwhile.
    task automatic wait_ready(input int k, input int exp_n, input string nm, input bit storm);
        int n = 0;
        while (!rdy[k] && n < 2000) begin
            if (storm) begin
                mrd[k] = 1'b1; mwr[k] = 1'b1; strb[k] = 4'hF;
                addr[k] = 8'(n); din[k] = 32'hFFFF_FFFF;
            end
            @(posedge clk); #1;
            n++;
        end
        mrd[k] = 1'b0; mwr[k] = 1'b0; strb[k] = 4'h0;
        chk(nm, 64'(n), 64'(exp_n));
    endtask

    task automatic chk_reset(input int k);
        chk($sformatf("dut%0d reset rd_data", k), {32'd0, rdat[k]}, 64'd0);
        chk($sformatf("dut%0d reset rd_valid", k), {63'd0, rval[k]}, 64'd0);
        chk($sformatf("dut%0d reset addr_err", k), {63'd0, aerr[k]}, 64'd0);
        chk($sformatf("dut%0d reset ready", k), {63'd0, rdy[k]}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; mrd[k] = 1'b0; mwr[k] = 1'b0;
            strb[k] = 4'h0; addr[k] = 8'h0; din[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset(0);
        chk_reset(1);
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;

        // T1: clear sweep length, then every word reads zero
        fork
            wait_ready(0, 256, "T1 dut0 clear cycles", 1'b0);
            wait_ready(1, 200, "T4 dut1 clear cycles", 1'b0);
        join
        for (int a = 0; a < 256; a++) op(0, 1'b1, 1'b0, 4'h0, 8'(a), 32'h0, 32'h0, 1'b0);

        // T2: full write then partial strobe merge
        op(0, 1'b0, 1'b1, 4'hF, 8'd5, 32'hAABB_CCDD, 32'h0, 1'b0);
        op(0, 1'b0, 1'b1, 4'h5, 8'd5, 32'h1122_3344, 32'h0, 1'b0);
        op(0, 1'b1, 1'b0, 4'h0, 8'd5, 32'h0, 32'hAA22_CC44, 1'b0);
        op(0, 1'b0, 1'b1, 4'h0, 8'd5, 32'hDEAD_BEEF, 32'h0, 1'b0);
        op(0, 1'b1, 1'b0, 4'h0, 8'd5, 32'h0, 32'hAA22_CC44, 1'b0);

        // T3: same-cycle read/write is write-first; top address boundary
        op(0, 1'b1, 1'b1, 4'hF, 8'd9, 32'h0000_005A, 32'h0000_005A, 1'b0);
        op(0, 1'b1, 1'b0, 4'h0, 8'd9, 32'h0, 32'h0000_005A, 1'b0);
        op(0, 1'b0, 1'b1, 4'hF, 8'd255, 32'hCAFE_F00D, 32'h0, 1'b0);
        op(0, 1'b1, 1'b0, 4'h0, 8'd255, 32'h0, 32'hCAFE_F00D, 1'b0);
        op(0, 1'b1, 1'b1, 4'h3, 8'd255, 32'h1234_5678, 32'hCAFE_5678, 1'b0);
        idle(0);

        // T4: out-of-range accesses on the DEPTH=200 instance
        op(1, 1'b0, 1'b1, 4'hF, 8'd199, 32'h1234_5678, 32'h0, 1'b0);
        op(1, 1'b0, 1'b1, 4'hF, 8'd210, 32'h0000_00FF, 32'h0, 1'b1);
        op(1, 1'b1, 1'b0, 4'h0, 8'd210, 32'h0, 32'h0, 1'b1);
        op(1, 1'b1, 1'b0, 4'h0, 8'd199, 32'h0, 32'h1234_5678, 1'b0);
        op(1, 1'b1, 1'b1, 4'hF, 8'd200, 32'h0000_0077, 32'h0, 1'b1);
        op(1, 1'b1, 1'b0, 4'h0, 8'd0, 32'h0, 32'h0, 1'b0);
        idle(1);
        repeat (3) @(posedge clk);

        // T5: reset mid-sweep restarts it; requests during CLEAR are dropped
        #1;
        rst[0] = 1'b1;
        #1;
        chk_reset(0);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        for (int n = 0; n < 100; n++) begin
            mrd[0] = 1'b1; mwr[0] = 1'b1; strb[0] = 4'hF;
            addr[0] = 8'(n + 3); din[0] = 32'hFFFF_FFFF;
            @(posedge clk); #1;
        end
        rst[0] = 1'b1;
        mrd[0] = 1'b0; mwr[0] = 1'b0;
        #1;
        chk("T5 ready low in mid-sweep reset", {63'd0, rdy[0]}, 64'd0);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        wait_ready(0, 256, "T5 restarted clear cycles", 1'b1);
        for (int a = 0; a < 256; a++) op(0, 1'b1, 1'b0, 4'h0, 8'(a), 32'h0, 32'h0, 1'b0);
        idle(0);
        repeat (4) @(posedge clk);
        #1;
        chk("dut0 outstanding responses", 64'(q0.size()), 64'd0);
        chk("dut1 outstanding responses", 64'(q1.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
